fetch_req_ctl: RTL and testbench

FETCH_REQ_CTL -- requirements
Module: fetch_req_ctl

---
 rtl/fetch_req_ctl_pkg.sv | 29 ++
 rtl/fetch_req_ctl_if.sv | 20 ++
 rtl/fetch_line_fifo.sv | 50 +++++
 rtl/fetch_req_ctl.sv | 84 ++++++++
 tb/tb_fetch_req_ctl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_req_ctl_pkg.sv
// fetch_req_ctl_pkg: memory request/response types and fetch-line types shared by the fetch request controller
package mem_common;
  localparam int MEM_ID_BITS = 4;
  localparam int MEM_DATA_BITS = 128;
  localparam int MEM_ADDR_BITS = 32;
  typedef struct packed {
    logic                     valid;
    logic [MEM_ID_BITS-1:0]   id;
    logic [MEM_ADDR_BITS-1:0] addr;
  } t_mem_req;
  typedef struct packed {
    logic                     valid;
    logic [MEM_ID_BITS-1:0]   id;
    logic [MEM_DATA_BITS-1:0] data;
  } t_mem_rsp;
endpackage

package fetch_req_ctl_pkg;
  import mem_common::*;
  localparam int FETCH_LINE_BYTES = 16;
  localparam int LINE_OFS_BITS = $clog2(FETCH_LINE_BYTES);
  typedef struct packed {
    logic [31:0]              pc;
    logic [MEM_DATA_BITS-1:0] data;
  } t_fetch_line;
  function automatic logic [31:0] line_align(input logic [31:0] a);
    return {a[31:LINE_OFS_BITS], {LINE_OFS_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/fetch_req_ctl_if.sv
// fetch_req_ctl_if: redirect input, icache req/rsp and decode line handshake; slave = controller, master = environment
interface fetch_req_ctl_if;
  import mem_common::*;
  logic                     redirect_nnn;
  logic [31:0]              redirect_pc_nnn;
  t_mem_req                 fb_ic_req_nnn;
  t_mem_rsp                 ic_fb_rsp_nnn;
  logic                     line_valid_fb1;
  logic [31:0]              line_pc_fb1;
  logic [MEM_DATA_BITS-1:0] line_data_fb1;
  logic                     line_ready_fb1;
  modport slave (
    input  redirect_nnn, redirect_pc_nnn, ic_fb_rsp_nnn, line_ready_fb1,
    output fb_ic_req_nnn, line_valid_fb1, line_pc_fb1, line_data_fb1
  );
  modport master (
    output redirect_nnn, redirect_pc_nnn, ic_fb_rsp_nnn, line_ready_fb1,
    input  fb_ic_req_nnn, line_valid_fb1, line_pc_fb1, line_data_fb1
  );
endinterface

// File: rtl/fetch_line_fifo.sv
// fetch_line_fifo: flushable circular line buffer (clk, rst, flush_i, push_i/data_i, pop_i, valid_o/data_o head, count_o)
module fetch_line_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 160,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    do_pop = pop_i && (cnt_q != '0) && !flush_i;
    do_push = push_i && !flush_i;
    rd_d = flush_i ? '0 : do_pop ? ptr_inc(rd_q) : rd_q;
    wr_d = flush_i ? '0 : do_push ? ptr_inc(wr_q) : wr_q;
    cnt_d = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    valid_o = cnt_q != '0;
    data_o = mem_q[rd_q];
    count_o = cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(do_push && !do_pop && cnt_q == CW'(DEPTH)));
  a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= CW'(DEPTH));
endmodule

// File: rtl/fetch_req_ctl.sv
// fetch_req_ctl: credit-limited icache line fetcher with redirect/stale tracking (clk, reset, bus: redirect, icache req/rsp, decode line)
module fetch_req_ctl
  import mem_common::*;
  import fetch_req_ctl_pkg::*;
#(
  parameter int          NUM_OUTST = 4,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic            clk,
  input logic            reset,
  fetch_req_ctl_if.slave bus
);
  localparam int CW = $clog2(NUM_OUTST) + 1;
  localparam int SW = (NUM_OUTST > 1) ? $clog2(NUM_OUTST) : 1;
  localparam int LW = $bits(t_fetch_line);
  logic [31:0] pc_q, pc_d;
  logic [CW-1:0] infl_q, infl_d, fifo_cnt;
  logic [SW-1:0] alloc_q, alloc_d, oldest_q, oldest_d;
  logic [31:0] slot_pc_q [NUM_OUTST];
  logic [31:0] slot_pc_d [NUM_OUTST];
  logic [NUM_OUTST-1:0] stale_q, stale_d;
  logic issued_any_q, issued_any_d;
  logic issue, rsp_fire, push, pop, line_valid;
  t_fetch_line push_line, head_line;
  function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
    return (s == SW'(NUM_OUTST - 1)) ? '0 : s + 1'b1;
  endfunction
  always_comb begin
    issue = !reset && !bus.redirect_nnn && (({1'b0, infl_q} + {1'b0, fifo_cnt}) < (CW+1)'(NUM_OUTST));
    rsp_fire = bus.ic_fb_rsp_nnn.valid && (infl_q != '0);
    push = rsp_fire && !stale_q[oldest_q] && !bus.redirect_nnn;
    pop = line_valid && bus.line_ready_fb1;
    push_line = t_fetch_line'{pc: slot_pc_q[oldest_q], data: bus.ic_fb_rsp_nnn.data};
    pc_d = bus.redirect_nnn ? bus.redirect_pc_nnn : issue ? line_align(pc_q) + 32'(FETCH_LINE_BYTES) : pc_q;
    infl_d = infl_q + CW'(issue) - CW'(rsp_fire);
    alloc_d = issue ? slot_inc(alloc_q) : alloc_q;
    oldest_d = rsp_fire ? slot_inc(oldest_q) : oldest_q;
    issued_any_d = issued_any_q || issue;
    for (int s = 0; s < NUM_OUTST; s++) begin
      slot_pc_d[s] = (issue && alloc_q == SW'(s)) ? pc_q : slot_pc_q[s];
      stale_d[s] = (issue && alloc_q == SW'(s)) ? 1'b0 : (bus.redirect_nnn || stale_q[s]);
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_q <= RESET_PC;
      infl_q <= '0;
      alloc_q <= '0;
      oldest_q <= '0;
      stale_q <= '0;
      issued_any_q <= 1'b0;
      slot_pc_q <= '{default: '0};
    end else begin
      pc_q <= pc_d;
      infl_q <= infl_d;
      alloc_q <= alloc_d;
      oldest_q <= oldest_d;
      stale_q <= stale_d;
      issued_any_q <= issued_any_d;
      slot_pc_q <= slot_pc_d;
    end
  always_comb begin
    bus.fb_ic_req_nnn = issue ? t_mem_req'{valid: 1'b1, id: MEM_ID_BITS'(alloc_q), addr: line_align(pc_q)} : t_mem_req'('0);
    bus.line_valid_fb1 = line_valid;
    bus.line_pc_fb1 = line_valid ? head_line.pc : '0;
    bus.line_data_fb1 = line_valid ? head_line.data : '0;
  end
  fetch_line_fifo #(.DEPTH(NUM_OUTST), .WIDTH(LW)) u_line_fifo (
    .clk     (clk),
    .rst     (reset),
    .flush_i (bus.redirect_nnn),
    .push_i  (push),
    .data_i  (push_line),
    .pop_i   (pop),
    .valid_o (line_valid),
    .data_o  (head_line),
    .count_o (fifo_cnt)
  );
  a_rsp_in_order: assert property (@(posedge clk) disable iff (reset)
    rsp_fire |-> bus.ic_fb_rsp_nnn.id == MEM_ID_BITS'(oldest_q));
  a_rsp_spurious: assert property (@(posedge clk) disable iff (reset)
    (bus.ic_fb_rsp_nnn.valid && issued_any_q) |-> infl_q != '0);
  a_infl_range: assert property (@(posedge clk) disable iff (reset) infl_q <= CW'(NUM_OUTST));
endmodule

// File: tb/tb_fetch_req_ctl.sv
// tb_fetch_req_ctl: randomized and directed checks of fetch_req_ctl against a transaction-level queue model
module tb_fetch_req_ctl;
  import mem_common::*;
  import fetch_req_ctl_pkg::*;
  localparam int N = 4;
  localparam logic [31:0] RPC = 32'h0;
  typedef struct { logic [31:0] pc; logic [127:0] data; } line_t;
  typedef struct { bit stale; logic [31:0] pc; } slot_t;
  typedef struct { int due; logic [3:0] id; logic [127:0] data; } icr_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  fetch_req_ctl_if bus();
  fetch_req_ctl #(.NUM_OUTST(N), .RESET_PC(RPC)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  slot_t m_infl[$];
  line_t m_lines[$];
  icr_t ic_q[$];
  logic [31:0] m_pc;
  int m_id, cyc, lat, vectors, errors;
  bit o_req_v, o_line_v, o_popped;
  logic [31:0] o_req_a, o_line_pc;
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic drive_idle();
    bus.redirect_nnn = 1'b0;
    bus.redirect_pc_nnn = '0;
    bus.ic_fb_rsp_nnn = '0;
    bus.line_ready_fb1 = 1'b1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    m_infl.delete();
    m_lines.delete();
    ic_q.delete();
    m_pc = RPC;
    m_id = 0;
    cyc = 0;
    reset = 1'b0;
  endtask
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy, input bit stray);
    bit take, exp_v;
    icr_t r;
    slot_t s;
    take = 1'b0;
    bus.redirect_nnn = redir;
    bus.redirect_pc_nnn = rpc;
    bus.line_ready_fb1 = rdy;
    if (stray) bus.ic_fb_rsp_nnn = t_mem_rsp'{valid: 1'b1, id: 4'($urandom), data: rnd128()};
    else if (ic_q.size() != 0 && ic_q[0].due <= cyc) begin
      r = ic_q.pop_front();
      take = 1'b1;
      bus.ic_fb_rsp_nnn = t_mem_rsp'{valid: 1'b1, id: r.id, data: r.data};
    end else bus.ic_fb_rsp_nnn = '0;
    #1;
    exp_v = !redir && (m_infl.size() + m_lines.size() < N);
    o_req_v = bus.fb_ic_req_nnn.valid;
    o_req_a = bus.fb_ic_req_nnn.addr;
    o_line_v = bus.line_valid_fb1;
    o_line_pc = bus.line_pc_fb1;
    o_popped = o_line_v && rdy;
    vectors++;
    if (o_req_v !== exp_v) begin
      errors++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, o_req_v, exp_v);
    end
    if (exp_v) begin
      vectors++;
      if (o_req_a !== (m_pc & ~32'hF) || bus.fb_ic_req_nnn.id !== 4'(m_id)) begin
        errors++;
        $display("FAIL req_addr_id cyc=%0d got=%h/%0d exp=%h/%0d", cyc, o_req_a, bus.fb_ic_req_nnn.id, m_pc & ~32'hF, m_id);
      end
    end
    vectors++;
    if (o_line_v !== (m_lines.size() != 0)) begin
      errors++;
      $display("FAIL line_valid cyc=%0d got=%b exp=%b", cyc, o_line_v, m_lines.size() != 0);
    end
    if (m_lines.size() != 0) begin
      vectors++;
      if (o_line_pc !== m_lines[0].pc || bus.line_data_fb1 !== m_lines[0].data) begin
        errors++;
        $display("FAIL line_head cyc=%0d got=%h/%h exp=%h/%h", cyc, o_line_pc, bus.line_data_fb1, m_lines[0].pc, m_lines[0].data);
      end
    end
    if (m_lines.size() != 0 && rdy && !redir) void'(m_lines.pop_front());
    if (take) begin
      s = m_infl.pop_front();
      if (!s.stale && !redir) m_lines.push_back('{s.pc, r.data});
    end
    if (redir) begin
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_lines.delete();
      m_pc = rpc;
    end
    if (exp_v) begin
      m_infl.push_back('{1'b0, m_pc});
      ic_q.push_back('{cyc + lat, 4'(m_id), rnd128()});
      m_id = (m_id + 1) % N;
      m_pc = (m_pc & ~32'hF) + 32'h10;
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic check_outputs_zero(input string tag);
    vectors++;
    if (bus.fb_ic_req_nnn !== '0 || bus.line_valid_fb1 !== 1'b0 || bus.line_pc_fb1 !== '0 || bus.line_data_fb1 !== '0) begin
      errors++;
      $display("FAIL %s got req=%h lv=%b pc=%h data=%h exp all zero", tag, bus.fb_ic_req_nnn, bus.line_valid_fb1, bus.line_pc_fb1, bus.line_data_fb1);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    #1;
    check_outputs_zero("reset_outputs");
    bus.redirect_pc_nnn = 32'h55;
    #1;
    check_outputs_zero("reset_outputs_redirpc");
  endtask
  task automatic test_stream();
    logic [31:0] addrs[$];
    int first_v, early;
    lat = 5;
    do_reset();
    first_v = -1;
    early = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (o_req_v) addrs.push_back(o_req_a);
      if (o_req_v && i < 7) early++;
      if (o_line_v && first_v < 0) first_v = i;
    end
    vectors++;
    if (first_v != 6) begin
      errors++;
      $display("FAIL stream_first_valid got=%0d exp=6", first_v);
    end
    vectors++;
    if (early != 4) begin
      errors++;
      $display("FAIL stream_stall got=%0d exp=4", early);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (addrs.size() <= i || addrs[i] !== 32'(i * 16)) begin
        errors++;
        $display("FAIL stream_addr%0d got=%h exp=%h", i, addrs.size() > i ? addrs[i] : 32'hx, 32'(i * 16));
      end
    end
  endtask
  task automatic test_backpressure();
    int nreq, npop;
    lat = 5;
    do_reset();
    nreq = 0;
    npop = 0;
    repeat (30) begin
      step(1'b0, '0, 1'b0, 1'b0);
      if (o_req_v) nreq++;
    end
    vectors++;
    if (nreq != 4) begin
      errors++;
      $display("FAIL bp_requests got=%0d exp=4", nreq);
    end
    repeat (5) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (o_popped) npop++;
    end
    vectors++;
    if (npop != 4) begin
      errors++;
      $display("FAIL bp_buffered got=%0d exp=4", npop);
    end
    repeat (10) step(1'b0, '0, 1'($urandom), 1'b0);
  endtask
  task automatic test_redirect();
    logic [31:0] first_a;
    logic [31:0] pcs[$];
    bit got;
    lat = 5;
    do_reset();
    got = 1'b0;
    first_a = 'x;
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h1234, 1'b1, 1'b0);
    repeat (20) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (o_req_v && !got) begin
        first_a = o_req_a;
        got = 1'b1;
      end
      if (o_popped) pcs.push_back(o_line_pc);
    end
    vectors++;
    if (first_a !== 32'h1230) begin
      errors++;
      $display("FAIL redir_req_addr got=%h exp=00001230", first_a);
    end
    vectors++;
    if (pcs.size() < 2 || pcs[0] !== 32'h1234 || pcs[1] !== 32'h1240) begin
      errors++;
      $display("FAIL redir_line_pcs got=%h,%h exp=00001234,00001240", pcs.size() > 0 ? pcs[0] : 32'hx, pcs.size() > 1 ? pcs[1] : 32'hx);
    end
  endtask
  task automatic test_collide();
    lat = 5;
    do_reset();
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h4000, 1'b1, 1'b0);
    vectors++;
    if (o_line_v !== 1'b1) begin
      errors++;
      $display("FAIL collide_pre_valid got=%b exp=1", o_line_v);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    vectors++;
    if (o_line_v !== 1'b0) begin
      errors++;
      $display("FAIL collide_flushed got=%b exp=0", o_line_v);
    end
    repeat (15) step(1'b0, '0, 1'b1, 1'b0);
  endtask
  task automatic test_wrap();
    logic [31:0] a[$];
    lat = 3;
    do_reset();
    step(1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0);
    repeat (4) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (o_req_v) a.push_back(o_req_a);
    end
    vectors++;
    if (a.size() < 2 || a[0] !== 32'hFFFF_FFF0 || a[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr got=%h,%h exp=fffffff0,00000000", a.size() > 0 ? a[0] : 32'hx, a.size() > 1 ? a[1] : 32'hx);
    end
    repeat (10) step(1'b0, '0, 1'b1, 1'b0);
  endtask
  task automatic test_async_reset();
    lat = 5;
    do_reset();
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_outputs_zero("async_reset_outputs");
    @(negedge clk);
    m_infl.delete();
    m_lines.delete();
    ic_q.delete();
    m_pc = RPC;
    m_id = 0;
    cyc = 0;
    reset = 1'b0;
    step(1'b0, '0, 1'b1, 1'b1);
    vectors++;
    if (o_req_v !== 1'b1 || o_req_a !== RPC) begin
      errors++;
      $display("FAIL post_reset_req got=%b/%h exp=1/%h", o_req_v, o_req_a, RPC);
    end
    repeat (20) step(1'b0, '0, 1'($urandom), 1'b0);
  endtask
  task automatic test_random();
    for (int seg = 0; seg < 3; seg++) begin
      lat = $urandom_range(1, 7);
      do_reset();
      repeat (300) step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0, 1'b0);
    end
  endtask
  initial begin
    vectors = 0;
    errors = 0;
    lat = 5;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_collide();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
